// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, node FSM encoding and Q8.8 constants for the neuron compute node
package nn_pkg;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int ACC_W  = 40;
   localparam int CNT_W  = 10;
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ACCUM     = 3'd1,
      S_WAIT_BIAS = 3'd2,
      S_ACT       = 3'd3,
      S_DONE      = 3'd4
   } node_state_t;
   localparam logic signed [DATA_W-1:0] ONE     = 16'sh0100;
   localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/node_mac.sv
// node_mac: signed DATA_W x DATA_W multiply feeding a sign-extended ACC_W accumulator
module node_mac
   import nn_pkg::*;
(
   input  logic                    clock,
   input  logic                    rst,
   input  logic                    clear_i,
   input  logic                    en_i,
   input  logic signed [DATA_W-1:0] x_i,
   input  logic signed [DATA_W-1:0] w_i,
   output logic signed [ACC_W-1:0]  acc_o
);
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_q;
   assign prod  = x_i * w_i;
   assign acc_o = acc_q;
   // Clear wins over accumulate so a restart never folds in a stale beat
   always_ff @(posedge clock) begin
      if (rst || clear_i) acc_q <= '0;
      else if (en_i) acc_q <= acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end
endmodule

// File: rtl/neuron_node.sv
// neuron_node: streams (x,w) beats and a bias, rescales, optional ReLU; NODE_SATURATE_EN clamps instead of wrapping
module neuron_node
   import nn_pkg::*;
(
   input  logic              clock,
   input  logic              rst,
   input  logic              head_c2node,
   input  logic              data_select_c2node,
   input  logic [CNT_W-1:0]  n_inputs_c2node,
   input  logic              relu_en_c2node,
   input  logic              valid_mem2node,
   input  logic [DATA_W-1:0] x_mem2node,
   input  logic [DATA_W-1:0] w_mem2node,
   input  logic [DATA_W-1:0] b_mem2node,
   output logic              busy_node2c,
   output logic              done_flag_node2c,
   output logic [DATA_W-1:0] result_node2mem
);
   node_state_t             state_q;
   logic [CNT_W-1:0]        cnt_q, n_q;
   logic                    relu_q, busy_q, done_q, mac_en;
   logic [DATA_W-1:0]       result_q, result_d;
   logic signed [DATA_W-1:0] mac_x, mac_w;
   logic signed [ACC_W-1:0] acc, r;
`ifdef NODE_SATURATE_EN
   logic signed [ACC_W-1:0] rr;
`endif
   assign busy_node2c      = busy_q;
   assign done_flag_node2c = done_q;
   assign result_node2mem  = result_q;
   // Bias reuses the multiplier: b * ONE is b shifted up by FRAC_W
   always_comb begin
      mac_en = valid_mem2node && ((state_q == S_ACCUM && !data_select_c2node) || (state_q == S_WAIT_BIAS && data_select_c2node));
      mac_x  = state_q == S_WAIT_BIAS ? b_mem2node : x_mem2node;
      mac_w  = state_q == S_WAIT_BIAS ? ONE : w_mem2node;
   end
   node_mac u_mac (
      .clock   (clock),
      .rst     (rst),
      .clear_i (head_c2node),
      .en_i    (mac_en),
      .x_i     (mac_x),
      .w_i     (mac_w),
      .acc_o   (acc)
   );
   // Rescale to Q8.8 (floor), optional ReLU, then wrap or clamp to DATA_W
   always_comb begin
      r = acc >>> FRAC_W;
`ifdef NODE_SATURATE_EN
      rr       = (relu_q && r < 0) ? '0 : r;
      result_d = rr > SAT_MAX ? SAT_MAX : rr < SAT_MIN ? SAT_MIN : rr[DATA_W-1:0];
`else
      result_d = (relu_q && r < 0) ? '0 : r[DATA_W-1:0];
`endif
   end
   // Node FSM; head restarts from any state, the done pulse is the DONE state itself
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         n_q      <= '0;
         relu_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (head_c2node) begin
            state_q <= n_inputs_c2node == '0 ? S_WAIT_BIAS : S_ACCUM;
            cnt_q   <= '0;
            n_q     <= n_inputs_c2node;
            relu_q  <= relu_en_c2node;
            busy_q  <= 1'b1;
         end else begin
            case (state_q)
               S_ACCUM: if (valid_mem2node && !data_select_c2node) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == n_q - CNT_W'(1)) state_q <= S_WAIT_BIAS;
               end
               S_WAIT_BIAS: if (valid_mem2node && data_select_c2node) state_q <= S_ACT;
               S_ACT: begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_DONE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_neuron_node.sv
// tb_neuron_node: directed and randomized neurons checked against an arithmetic reference model
module tb_neuron_node;
   import nn_pkg::*;
   logic clock = 1'b0, rst = 1'b1, head = 1'b0, ds = 1'b0, relu_in = 1'b0, valid = 1'b0;
   logic [CNT_W-1:0] n_in = '0;
   logic [DATA_W-1:0] x = '0, w = '0, b = '0;
   logic busy, done;
   logic [DATA_W-1:0] result;
   int checks = 0, failures = 0, done_cnt = 0, exp_done = 0;
   logic signed [DATA_W-1:0] xs[16], ws[16], b_cur;
   int n_cur;
   bit relu_cur;
   bit chain;

   neuron_node dut (
      .clock              (clock),
      .rst                (rst),
      .head_c2node        (head),
      .data_select_c2node (ds),
      .n_inputs_c2node    (n_in),
      .relu_en_c2node     (relu_in),
      .valid_mem2node     (valid),
      .x_mem2node         (x),
      .w_mem2node         (w),
      .b_mem2node         (b),
      .busy_node2c        (busy),
      .done_flag_node2c   (done),
      .result_node2mem    (result)
   );

   always #5 clock = ~clock;
   always @(posedge clock) if (done) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   function automatic logic [15:0] ref_res();
      longint acc = 0, r;
      for (int i = 0; i < n_cur; i++) acc += longint'(xs[i]) * longint'(ws[i]);
      acc += longint'(b_cur) * 256;
      r = acc >>> 8;
      if (relu_cur && r < 0) r = 0;
`ifdef NODE_SATURATE_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`endif
      return r[15:0];
   endfunction

   task automatic do_head(input int n, input bit relu);
      n_cur = n;
      relu_cur = relu;
      n_in = CNT_W'(n);
      relu_in = relu;
      head = 1'b1;
      tick();
      head = 1'b0;
   endtask

   task automatic stall(input int lo, input int hi, input bit bias_phase);
      repeat ($urandom_range(hi, lo)) begin
         valid = 1'($urandom);
         ds = !bias_phase;
         x = 16'($urandom);
         w = 16'($urandom);
         b = 16'($urandom);
         tick();
      end
      valid = 1'b0;
   endtask

   task automatic feed(input int lo, input int hi);
      check("busy_run", 32'(busy), 1);
      for (int i = 0; i < n_cur; i++) begin
         stall(lo, hi, 1'b0);
         valid = 1'b1;
         ds = 1'b0;
         x = xs[i];
         w = ws[i];
         b = 16'($urandom);
         tick();
      end
      stall(lo, hi, 1'b1);
      valid = 1'b1;
      ds = 1'b1;
      b = b_cur;
      x = 16'($urandom);
      w = 16'($urandom);
      tick();
      valid = 1'b0;
      check("act_busy", 32'(busy), 1);
      check("act_no_done", 32'(done), 0);
   endtask

   task automatic finish(input string tag);
      logic [15:0] e;
      e = ref_res();
      tick();
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_res"}, 32'(result), 32'(e));
      check({tag, "_busy"}, 32'(busy), 0);
      exp_done++;
   endtask

   task automatic gen();
      n_cur = $urandom_range(8, 0);
      relu_cur = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
         xs[i] = 16'($urandom);
         ws[i] = 16'($urandom);
      end
      b_cur = 16'($urandom);
   endtask

   task automatic set_t1();
      xs[0] = 16'h0100; xs[1] = 16'h0200; xs[2] = 16'h0080;
      ws[0] = 16'h0100; ws[1] = 16'h0100; ws[2] = 16'h0200;
      b_cur = 16'h0100;
   endtask

   initial begin
      tick();
      tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_result", 32'(result), 0);
      rst = 1'b0;
      tick();

      set_t1();
      do_head(3, 1'b1);
      feed(0, 0);
      finish("t1");
      check("t1_const", 32'(result), 32'h0500);
      tick();
      check("t1_pulse_width", 32'(done), 0);
      check("t1_hold", 32'(result), 32'h0500);

      xs[0] = 16'h0100; ws[0] = 16'hFE00; b_cur = 16'h0000;
      do_head(1, 1'b1);
      feed(0, 0);
      finish("t2_relu");
      check("t2_relu_const", 32'(result), 32'h0000);
      tick();
      do_head(1, 1'b0);
      feed(0, 0);
      finish("t2_norelu");
      check("t2_norelu_const", 32'(result), 32'hFE00);
      tick();

      xs[0] = 16'h7FFF; xs[1] = 16'h7FFF; ws[0] = 16'h7FFF; ws[1] = 16'h7FFF; b_cur = 16'h0000;
      do_head(2, 1'b0);
      feed(0, 0);
      finish("t3");
`ifdef NODE_SATURATE_EN
      check("t3_const", 32'(result), 32'h7FFF);
`else
      check("t3_const", 32'(result), 32'hFE00);
`endif
      tick();

      for (int i = 0; i < 4; i++) begin
         xs[i] = 16'h0100;
         ws[i] = 16'h0100;
      end
      b_cur = 16'h0000;
      do_head(4, 1'b1);
      repeat (2) begin
         valid = 1'b1; ds = 1'b0; x = 16'h0100; w = 16'h0100;
         tick();
      end
      valid = 1'b0;
      do_head(4, 1'b0);
      feed(0, 0);
      finish("t4");
      check("t4_const", 32'(result), 32'h0400);
      tick();
      check("t4_one_done", 32'(done_cnt), 32'(exp_done));

      b_cur = 16'h0300;
      do_head(0, 1'b1);
      feed(0, 0);
      finish("t5");
      check("t5_const", 32'(result), 32'h0300);
      tick();
      set_t1();
      do_head(3, 1'b1);
      feed(3, 3);
      finish("t5_stall");
      check("t5_stall_const", 32'(result), 32'h0500);
      tick();

      do_head(4, 1'b1);
      repeat (2) begin
         valid = 1'b1; ds = 1'b0; x = 16'h0100; w = 16'h0100;
         tick();
      end
      valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy", 32'(busy), 0);
      check("t6_done", 32'(done), 0);
      check("t6_result", 32'(result), 0);
      tick();
      set_t1();
      do_head(3, 1'b1);
      feed(0, 1);
      finish("t6_clean");
      check("t6_clean_const", 32'(result), 32'h0500);
      tick();
      check("t6_done_count", 32'(done_cnt), 32'(exp_done));

      chain = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (!chain) begin
            gen();
            do_head(n_cur, relu_cur);
         end
         feed(0, 2);
         finish("rnd");
         chain = 1'($urandom);
         if (chain) begin
            gen();
            do_head(n_cur, relu_cur);
         end else tick();
         check("rnd_pulse_width", 32'(done), 0);
      end
      if (chain) begin
         feed(0, 0);
         finish("rnd_last");
      end
      tick();
      tick();
      check("done_count", 32'(done_cnt), 32'(exp_done));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
